// File: rtl/dma_sched_pkg.sv
// Shared types for the DMA command scheduler: descriptor layout, FSM states and
// the read-engine command code that also kicks the encoder.
package dma_sched_pkg;

    localparam int unsigned DMA_ADDR_WIDTH = 64;
    localparam int unsigned DMA_SIZE_WIDTH = 32;
    localparam logic [31:0] ENC_CMD        = 32'd2;

    typedef struct packed {
        logic                      dir;
        logic [31:0]               rd_command;
        logic [DMA_ADDR_WIDTH-1:0] base_addr;
        logic [DMA_ADDR_WIDTH-1:0] data_ptr;
        logic [DMA_SIZE_WIDTH-1:0] size_bytes;
    } dma_cmd_t;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWaitDone,
        StRetire
    } sched_state_e;

endpackage

// File: rtl/dma_cmd_fifo.sv
// Synchronous descriptor FIFO; push while full and pop while empty are ignored.
module dma_cmd_fifo
    import dma_sched_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  dma_cmd_t             din,
    input  logic                 pop,
    output dma_cmd_t             dout,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_WIDTH-1:0] count
);

    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

    dma_cmd_t             mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 push_ok, pop_ok;

    assign full    = (count_q == CNT_WIDTH'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_WIDTH'(1);
                2'b01:   count_q <= count_q - CNT_WIDTH'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/dma_cmd_sched.sv
// Queues DMA descriptors and issues them one at a time to the read or write engine,
// tracking completions and flagging done pulses that arrive when none is expected.
module dma_cmd_sched
    import dma_sched_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH      = 64,
    parameter int unsigned AXI_XFER_SIZE_WIDTH = 32,
    parameter int unsigned CMD_DEPTH           = 4,
    parameter int unsigned CNT_WIDTH           = $clog2(CMD_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_cmd_valid,
    output logic                           o_cmd_ready,
    input  logic                           i_cmd_dir,
    input  logic [31:0]                    i_cmd_rd_command,
    input  logic [AXI_ADDR_WIDTH-1:0]      i_cmd_base_addr,
    input  logic [AXI_ADDR_WIDTH-1:0]      i_cmd_data_ptr,
    input  logic [AXI_XFER_SIZE_WIDTH-1:0] i_cmd_size_bytes,
    output logic                           o_rd_start,
    output logic                           o_wr_start,
    output logic [31:0]                    o_rd_command,
    output logic [AXI_ADDR_WIDTH-1:0]      o_base_addr,
    output logic [AXI_ADDR_WIDTH-1:0]      o_data_ptr,
    output logic [AXI_XFER_SIZE_WIDTH-1:0] o_data_size_bytes,
    output logic                           o_encode_cfg_start,
    input  logic                           i_rd_done,
    input  logic                           i_wr_done,
    output logic                           o_busy,
    output logic [CNT_WIDTH-1:0]           o_cmd_count,
    output logic [15:0]                    o_done_count,
    output logic                           o_err,
    input  logic                           i_clr_err
);

    sched_state_e state_q, state_d;
    dma_cmd_t     cmd_in, fifo_head, bus_q;
    logic         fifo_full, fifo_empty, fifo_pop;
    logic [15:0]  done_cnt_q;
    logic         err_q, err_set, in_wait, active_done, launch, size_zero;

    always_comb begin
        cmd_in            = '0;
        cmd_in.dir        = i_cmd_dir;
        cmd_in.rd_command = i_cmd_rd_command;
        cmd_in.base_addr  = DMA_ADDR_WIDTH'(i_cmd_base_addr);
        cmd_in.data_ptr   = DMA_ADDR_WIDTH'(i_cmd_data_ptr);
        cmd_in.size_bytes = DMA_SIZE_WIDTH'(i_cmd_size_bytes);
    end

    dma_cmd_fifo #(
        .DEPTH     (CMD_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (i_cmd_valid & o_cmd_ready),
        .din   (cmd_in),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_cmd_count)
    );

    assign o_cmd_ready = ~fifo_full;
    assign size_zero   = (bus_q.size_bytes == '0);
    assign in_wait     = (state_q == StWaitDone);
    assign active_done = bus_q.dir ? i_wr_done : i_rd_done;
    assign launch      = (state_q == StLaunch) & ~size_zero;

    // Only the active engine's done during WAIT_DONE is legitimate.
    assign err_set = (i_rd_done & ~(in_wait & ~bus_q.dir)) |
                     (i_wr_done & ~(in_wait &  bus_q.dir));

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = StLaunch;
                end
            end
            StLaunch:   state_d = size_zero ? StRetire : StWaitDone;
            StWaitDone: if (active_done) state_d = StRetire;
            StRetire:   state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            bus_q      <= '0;
            done_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fifo_pop)            bus_q      <= fifo_head;
            if (state_q == StRetire) done_cnt_q <= done_cnt_q + 16'd1;
            if (err_set)             err_q      <= 1'b1;
            else if (i_clr_err)      err_q      <= 1'b0;
        end
    end

    assign o_rd_start         = launch & ~bus_q.dir;
    assign o_wr_start         = launch &  bus_q.dir;
    assign o_encode_cfg_start = o_rd_start & (bus_q.rd_command == ENC_CMD);
    assign o_rd_command       = bus_q.rd_command;
    assign o_base_addr        = AXI_ADDR_WIDTH'(bus_q.base_addr);
    assign o_data_ptr         = AXI_ADDR_WIDTH'(bus_q.data_ptr);
    assign o_data_size_bytes  = AXI_XFER_SIZE_WIDTH'(bus_q.size_bytes);
    assign o_busy             = (state_q != StIdle) | (o_cmd_count != '0);
    assign o_done_count       = done_cnt_q;
    assign o_err              = err_q;

endmodule

// File: tb/tb_dma_cmd_sched.sv
// Scoreboard bench for dma_cmd_sched: accepted descriptors are queued and matched
// in order against every engine start; directed cases cover timing, full, error, reset.
module tb_dma_cmd_sched;
    import dma_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_cmd_valid = 1'b0, o_cmd_ready;
    logic        i_cmd_dir = 1'b0;
    logic [31:0] i_cmd_rd_command = '0;
    logic [63:0] i_cmd_base_addr = '0, i_cmd_data_ptr = '0;
    logic [31:0] i_cmd_size_bytes = '0;
    logic        o_rd_start, o_wr_start, o_encode_cfg_start;
    logic [31:0] o_rd_command;
    logic [63:0] o_base_addr, o_data_ptr;
    logic [31:0] o_data_size_bytes;
    logic        i_rd_done = 1'b0, i_wr_done = 1'b0;
    logic        o_busy, o_err;
    logic        i_clr_err = 1'b0;
    logic [2:0]  o_cmd_count;
    logic [15:0] o_done_count;

    int       n_cmp = 0;
    int       n_err = 0;
    int       n_retired = 0;
    bit       auto_resp = 1'b0;
    dma_cmd_t exp_q [$];

    dma_cmd_sched dut (
        .clk                (clk),
        .rst                (rst),
        .i_cmd_valid        (i_cmd_valid),
        .o_cmd_ready        (o_cmd_ready),
        .i_cmd_dir          (i_cmd_dir),
        .i_cmd_rd_command   (i_cmd_rd_command),
        .i_cmd_base_addr    (i_cmd_base_addr),
        .i_cmd_data_ptr     (i_cmd_data_ptr),
        .i_cmd_size_bytes   (i_cmd_size_bytes),
        .o_rd_start         (o_rd_start),
        .o_wr_start         (o_wr_start),
        .o_rd_command       (o_rd_command),
        .o_base_addr        (o_base_addr),
        .o_data_ptr         (o_data_ptr),
        .o_data_size_bytes  (o_data_size_bytes),
        .o_encode_cfg_start (o_encode_cfg_start),
        .i_rd_done          (i_rd_done),
        .i_wr_done          (i_wr_done),
        .o_busy             (o_busy),
        .o_cmd_count        (o_cmd_count),
        .o_done_count       (o_done_count),
        .o_err              (o_err),
        .i_clr_err          (i_clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic dma_cmd_t mk(input bit dir, input logic [31:0] cmd,
                                    input logic [63:0] base, input logic [63:0] ptr,
                                    input logic [31:0] size);
        dma_cmd_t c;
        c.dir        = dir;
        c.rd_command = cmd;
        c.base_addr  = base;
        c.data_ptr   = ptr;
        c.size_bytes = size;
        return c;
    endfunction

    function automatic dma_cmd_t rand_cmd();
        logic [31:0] cmd;
        logic [31:0] size;
        case ($urandom % 4)
            0:       cmd = 32'd0;
            1:       cmd = 32'd1;
            2:       cmd = 32'd2;
            default: cmd = $urandom;
        endcase
        size = ($urandom % 4 == 0) ? 32'd0 : 32'($urandom_range(1, 4096));
        return mk(1'($urandom), cmd, {$urandom, $urandom}, {$urandom, $urandom}, size);
    endfunction

    // Called at a falling edge; returns one falling edge later.
    task automatic push_cmd(input dma_cmd_t c, output bit acc);
        i_cmd_valid      = 1'b1;
        i_cmd_dir        = c.dir;
        i_cmd_rd_command = c.rd_command;
        i_cmd_base_addr  = c.base_addr;
        i_cmd_data_ptr   = c.data_ptr;
        i_cmd_size_bytes = c.size_bytes;
        acc = o_cmd_ready;
        if (acc) exp_q.push_back(c);
        @(negedge clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic pulse_done(input bit wr);
        if (wr) i_wr_done = 1'b1;
        else    i_rd_done = 1'b1;
        @(negedge clk);
        i_rd_done = 1'b0;
        i_wr_done = 1'b0;
    endtask

    // Single descriptor through an idle, empty scheduler with a manual engine response.
    task automatic run_one(input dma_cmd_t c, input int dly);
        bit          acc;
        bit          st;
        logic [15:0] d0;
        logic [15:0] d1;
        st = (c.size_bytes != 0);
        d0 = o_done_count;
        d1 = d0 + 16'd1;
        push_cmd(c, acc);
        check("push_accept", 64'(acc), 64'd1);
        check("count_after_push", 64'(o_cmd_count), 64'd1);
        @(negedge clk);
        check("rd_start_latency", 64'(o_rd_start), 64'(st & ~c.dir));
        check("wr_start_latency", 64'(o_wr_start), 64'(st & c.dir));
        check("enc_start", 64'(o_encode_cfg_start), 64'(st & ~c.dir & (c.rd_command == 32'd2)));
        if (st) begin
            repeat (dly) @(negedge clk);
            pulse_done(c.dir);
            check("done_cnt_in_retire", 64'(o_done_count), 64'(d0));
            @(negedge clk);
            check("done_cnt_after_done", 64'(o_done_count), 64'(d1));
        end else begin
            @(negedge clk);
            @(negedge clk);
            check("done_cnt_zero_size", 64'(o_done_count), 64'(d1));
        end
        @(negedge clk);
        check("busy_after_retire", 64'(o_busy), 64'd0);
    endtask

    task automatic wait_idle(input int max_cycles);
        bit idle = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (!o_busy) begin
                idle = 1'b1;
                break;
            end
        end
        check("drain_within_bound", 64'(idle), 64'd1);
    endtask

    // Trailing zero-size descriptors retire without a start; account for them here.
    task automatic drain_check();
        dma_cmd_t c;
        repeat (2) @(negedge clk);
        while (exp_q.size() != 0) begin
            c = exp_q.pop_front();
            check("leftover_is_zero_size", 64'(c.size_bytes), 64'd0);
            n_retired++;
        end
        check("done_count_total", 64'(o_done_count), 64'(16'(n_retired)));
        check("err_clear", 64'(o_err), 64'd0);
    endtask

    // Monitor: every start must match the oldest outstanding nonzero descriptor.
    initial begin
        dma_cmd_t c;
        bit       found;
        forever begin
            @(negedge clk);
            if (!rst && (o_rd_start || o_wr_start)) begin
                found = 1'b0;
                while (exp_q.size() != 0 && !found) begin
                    c = exp_q.pop_front();
                    if (c.size_bytes == 0) n_retired++;
                    else found = 1'b1;
                end
                check("start_expected", 64'(found), 64'd1);
                if (found) begin
                    check("sb_single_start", 64'(o_rd_start & o_wr_start), 64'd0);
                    check("sb_dir", 64'(o_wr_start), 64'(c.dir));
                    check("sb_rd_command", 64'(o_rd_command), 64'(c.rd_command));
                    check("sb_base_addr", o_base_addr, c.base_addr);
                    check("sb_data_ptr", o_data_ptr, c.data_ptr);
                    check("sb_size", 64'(o_data_size_bytes), 64'(c.size_bytes));
                    check("sb_enc", 64'(o_encode_cfg_start),
                          64'(~c.dir & (c.rd_command == 32'd2)));
                    check("sb_done_count", 64'(o_done_count), 64'(16'(n_retired)));
                    n_retired++;
                end
            end
        end
    end

    // Engine model: answers each start with the matching done after 1..6 cycles.
    initial begin
        bit wr;
        forever begin
            @(negedge clk);
            if (auto_resp && !rst && (o_rd_start || o_wr_start)) begin
                wr = o_wr_start;
                repeat ($urandom_range(1, 6)) @(negedge clk);
                pulse_done(wr);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit          acc;
        logic [15:0] d0;
        dma_cmd_t    c;

        #1;
        check("rst_ready", 64'(o_cmd_ready), 64'd1);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_count", 64'(o_cmd_count), 64'd0);
        check("rst_done_count", 64'(o_done_count), 64'd0);
        check("rst_starts", 64'({o_rd_start, o_wr_start, o_encode_cfg_start}), 64'd0);
        check("rst_bus", o_base_addr | o_data_ptr, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single read, encoder stream, non-encoder read, zero size, single write.
        run_one(mk(1'b0, 32'd0, 64'h100, 64'h8000_0000, 32'd4096), 50);
        run_one(mk(1'b0, 32'd2, 64'h200, 64'h1234_5678_9abc, 32'd64), 3);
        run_one(mk(1'b0, 32'd1, 64'h200, 64'h1234_5678_9abc, 32'd64), 3);
        run_one(mk(1'b1, 32'd2, 64'h300, 64'h40, 32'd0), 1);
        run_one(mk(1'b1, 32'd2, 64'hffff_0000, 64'h1, 32'd1), 1);

        // Back-to-back until full: one in flight plus CMD_DEPTH queued.
        d0 = o_done_count;
        for (int i = 0; i < 5; i++) begin
            push_cmd(mk(1'(i), 32'(i), 64'(i * 16), 64'(32'h1000 + i), 32'(i + 1)), acc);
            check("b2b_accept", 64'(acc), 64'd1);
        end
        check("full_ready_low", 64'(o_cmd_ready), 64'd0);
        check("full_count", 64'(o_cmd_count), 64'd4);
        push_cmd(mk(1'b0, 32'd9, 64'h9, 64'h9, 32'd9), acc);
        check("full_push_rejected", 64'(acc), 64'd0);
        check("full_count_held", 64'(o_cmd_count), 64'd4);
        auto_resp = 1'b1;
        pulse_done(1'b0);
        wait_idle(500);
        drain_check();
        check("b2b_done_delta", 64'(o_done_count - d0), 64'd5);
        auto_resp = 1'b0;

        // Wrong-engine done during a read, then normal retire, then clear.
        d0 = o_done_count;
        push_cmd(mk(1'b0, 32'd0, 64'h500, 64'h600, 32'd128), acc);
        repeat (3) @(negedge clk);
        pulse_done(1'b1);
        check("err_wrong_engine", 64'(o_err), 64'd1);
        check("err_still_busy", 64'(o_busy), 64'd1);
        check("err_no_retire", 64'(o_done_count), 64'(d0));
        pulse_done(1'b0);
        @(negedge clk);
        check("err_then_retire", 64'(o_done_count), 64'(d0 + 16'd1));
        check("err_sticky", 64'(o_err), 64'd1);
        i_clr_err = 1'b1;
        @(negedge clk);
        i_clr_err = 1'b0;
        check("err_cleared", 64'(o_err), 64'd0);
        // Stray done while idle together with clear: set wins.
        i_clr_err = 1'b1;
        pulse_done(1'b0);
        i_clr_err = 1'b0;
        check("err_set_wins", 64'(o_err), 64'd1);
        check("err_idle_no_count", 64'(o_done_count), 64'(d0 + 16'd1));
        i_clr_err = 1'b1;
        @(negedge clk);
        i_clr_err = 1'b0;

        // Reset mid-transfer with two queued.
        for (int i = 0; i < 3; i++) push_cmd(mk(1'b0, 32'd2, 64'(i), 64'(i), 32'd8), acc);
        @(negedge clk);
        check("pre_rst_count", 64'(o_cmd_count), 64'd2);
        rst = 1'b1;
        #1;
        check("async_rst_count", 64'(o_cmd_count), 64'd0);
        check("async_rst_busy", 64'(o_busy), 64'd0);
        check("async_rst_done", 64'(o_done_count), 64'd0);
        check("async_rst_ready", 64'(o_cmd_ready), 64'd1);
        check("async_rst_bus", o_base_addr | 64'(o_data_size_bytes), 64'd0);
        exp_q.delete();
        n_retired = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_one(mk(1'b1, 32'd0, 64'hab, 64'hcd, 32'd16), 2);

        // Randomized traffic against the scoreboard.
        auto_resp = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom % 3 == 0) begin
                c = rand_cmd();
                push_cmd(c, acc);
            end else begin
                @(negedge clk);
            end
        end
        wait_idle(3000);
        drain_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
